// File: rtl/uart_wb_pkg.sv
// Shared constants and state encoding for the UART-to-Wishbone bridge master.
// Imported by uart_wb_master and uart_wb_txser.
package uart_wb_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;  // 'W'
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR   = 8'h45;  // 'E'

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_e;

endpackage

// File: rtl/uart_wb_txser.sv
// Response serialiser: emits a status byte, optionally followed by a 32-bit word
// MSB first, one byte per transmitter handshake.
module uart_wb_txser
  import uart_wb_pkg::*;
(
  input  logic        i_clk,
  input  logic        in_rst,
  input  logic        i_start,
  input  logic        i_with_data,
  input  logic [7:0]  i_code,
  input  logic [31:0] i_data,
  input  logic        i_byte_tx_busy,
  output logic [7:0]  o_byte_tx_data,
  output logic        o_byte_tx_valid,
  output logic        o_idle
);

  logic [39:0] shreg_q, shreg_d;
  logic [2:0]  rem_q, rem_d;
  logic [1:0]  hold_q, hold_d;
  logic        fire;

  // Strobe is combinational on busy so a byte is never offered to a busy transmitter.
  assign fire            = (rem_q != 3'd0) && (hold_q == 2'd0) && !i_byte_tx_busy;
  assign o_byte_tx_valid = fire;
  assign o_byte_tx_data  = fire ? shreg_q[39:32] : 8'h00;
  assign o_idle          = (rem_q == 3'd0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    shreg_d = shreg_q;
    rem_d   = rem_q;
    hold_d  = (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
    if (i_start) begin
      shreg_d = {i_code, i_data};
      rem_d   = i_with_data ? 3'd5 : 3'd1;
    end else if (fire) begin
      shreg_d = {shreg_q[31:0], 8'h00};
      rem_d   = rem_q - 3'd1;
      hold_d  = 2'd2;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) begin
      shreg_q <= '0;
      rem_q   <= '0;
      hold_q  <= '0;
    end else begin
      shreg_q <= shreg_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: rtl/uart_wb_master.sv
// UART byte-stream to Wishbone master: 'W'/'R' frames become single word cycles.
// Optional ack timeout enabled by defining UART_WB_TIMEOUT_EN.
module uart_wb_master
  import uart_wb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        i_clk,
  input  logic        in_rst,
  input  logic [7:0]  i_byte_rx_data,
  input  logic        i_byte_rx_valid,
  output logic [7:0]  o_byte_tx_data,
  output logic        o_byte_tx_valid,
  input  logic        i_byte_tx_busy,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_stall,
  input  logic        i_wb_ack,
  input  logic [31:0] i_wb_data,
  output logic        o_busy
);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        cyc_q, cyc_d;
  logic        stb_q, stb_d;

  logic        tx_start, tx_with_data, tx_idle;
  logic [7:0]  tx_code;
  logic        bus_timeout;

`ifdef UART_WB_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d       = (state_q == ST_BUS) ? tmo_q + 1'b1 : '0;
    bus_timeout = (state_q == ST_BUS) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  assign bus_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    data_d       = data_q;
    cyc_d        = cyc_q;
    stb_d        = stb_q;
    tx_start     = 1'b0;
    tx_with_data = 1'b0;
    tx_code      = RSP_OK;
    unique case (state_q)
      ST_IDLE: begin
        if (i_byte_rx_valid &&
            (i_byte_rx_data == CMD_WRITE || i_byte_rx_data == CMD_READ)) begin
          we_d    = (i_byte_rx_data == CMD_WRITE);
          cnt_d   = 2'd0;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (i_byte_rx_valid) begin
          addr_d = {addr_q[23:0], i_byte_rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            if (we_q) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_BUS;
              cyc_d   = 1'b1;
              stb_d   = 1'b1;
            end
          end
        end
      end
      ST_DATA: begin
        if (i_byte_rx_valid) begin
          data_d = {data_q[23:0], i_byte_rx_data};
          cnt_d  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
          end
        end
      end
      ST_BUS: begin
        if (stb_q && !i_wb_stall) stb_d = 1'b0;
        // Ack wins over a timeout landing in the same cycle.
        if (i_wb_ack) begin
          cyc_d        = 1'b0;
          stb_d        = 1'b0;
          tx_start     = 1'b1;
          tx_with_data = !we_q;
          state_d      = ST_RESP;
        end else if (bus_timeout) begin
          cyc_d    = 1'b0;
          stb_d    = 1'b0;
          tx_start = 1'b1;
          tx_code  = RSP_ERR;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tx_idle) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
    end
  end

  // The read word is captured straight into the serialiser on the ack cycle.
  uart_wb_txser u_txser (
    .i_clk          (i_clk),
    .in_rst         (in_rst),
    .i_start        (tx_start),
    .i_with_data    (tx_with_data),
    .i_code         (tx_code),
    .i_data         (i_wb_data),
    .i_byte_tx_busy (i_byte_tx_busy),
    .o_byte_tx_data (o_byte_tx_data),
    .o_byte_tx_valid(o_byte_tx_valid),
    .o_idle         (tx_idle)
  );

  assign o_wb_cyc  = cyc_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_we   = cyc_q & we_q;
  assign o_wb_addr = addr_q;
  assign o_wb_data = data_q;
  assign o_wb_sel  = {4{cyc_q}};
  assign o_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_wb_master.sv
// Self-checking bench for uart_wb_master: directed frame table, reset and
// timeout sequences, then random frames against a frame-level reference model.
module tb_uart_wb_master;

`ifdef UART_WB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  o_byte_tx_data;
  logic        o_byte_tx_valid;
  logic        tx_busy;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_addr, o_wb_data;
  logic [3:0]  o_wb_sel;
  logic        i_wb_stall, i_wb_ack;
  logic [31:0] i_wb_data;
  logic        o_busy;

  always #5 clk = ~clk;

  uart_wb_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_clk          (clk),
    .in_rst         (rst_n),
    .i_byte_rx_data (rx_data),
    .i_byte_rx_valid(rx_valid),
    .o_byte_tx_data (o_byte_tx_data),
    .o_byte_tx_valid(o_byte_tx_valid),
    .i_byte_tx_busy (tx_busy),
    .o_wb_cyc       (o_wb_cyc),
    .o_wb_stb       (o_wb_stb),
    .o_wb_we        (o_wb_we),
    .o_wb_addr      (o_wb_addr),
    .o_wb_data      (o_wb_data),
    .o_wb_sel       (o_wb_sel),
    .i_wb_stall     (i_wb_stall),
    .i_wb_ack       (i_wb_ack),
    .i_wb_data      (i_wb_data),
    .o_busy         (o_busy)
  );

  typedef struct {
    string       name;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stall;
    int          ack_dly;
    int          busy_len;
    int          gap;
    bit          junk_en;
    logic [7:0]  junk;
    bit          junk_bus;
    bit          noack;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sel;
  } txn_t;

  int n_checks = 0;
  int n_errors = 0;
  int viol     = 0;

  // Slave configuration and observations.
  int          cfg_stall = 0, cfg_ack_dly = 0, busy_len = 0;
  bit          cfg_noack = 0;
  logic [31:0] cfg_rdata = '0;
  int          stb_cycles = 0, cyc_cycles = 0;
  txn_t        txn_q[$];
  logic [7:0]  tx_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wishbone slave: stalls the first cfg_stall stb cycles, acks cfg_ack_dly cycles after acceptance.
  initial begin
    int          stall_left;
    int          ack_wait;
    bit          cyc_seen;
    logic [31:0] first_addr, first_data;
    txn_t        t;
    i_wb_stall = 1'b0;
    i_wb_ack   = 1'b0;
    i_wb_data  = '0;
    stall_left = 0;
    ack_wait   = -1;
    cyc_seen   = 1'b0;
    first_addr = '0;
    first_data = '0;
    forever begin
      @(negedge clk);
      i_wb_ack = 1'b0;
      if (!o_wb_cyc) begin
        stall_left = cfg_stall;
        ack_wait   = -1;
        i_wb_stall = 1'b0;
        cyc_seen   = 1'b0;
      end else begin
        cyc_cycles++;
        if (!cyc_seen) begin
          first_addr = o_wb_addr;
          first_data = o_wb_data;
          cyc_seen   = 1'b1;
        end else if (o_wb_addr !== first_addr || o_wb_data !== first_data) begin
          viol++;
        end
        if (o_wb_sel !== 4'hF) viol++;
        if (ack_wait > 0) ack_wait--;
        if (o_wb_stb) begin
          stb_cycles++;
          if (ack_wait != -1) begin
            viol++;
          end else if (stall_left > 0) begin
            i_wb_stall = 1'b1;
            stall_left--;
          end else begin
            i_wb_stall = 1'b0;
            t.we   = o_wb_we;
            t.addr = o_wb_addr;
            t.data = o_wb_data;
            t.sel  = o_wb_sel;
            txn_q.push_back(t);
            ack_wait = cfg_ack_dly;
          end
        end
        if (ack_wait == 0 && !cfg_noack) begin
          i_wb_ack  = 1'b1;
          i_wb_data = cfg_rdata;
          ack_wait  = -2;
        end
      end
    end
  end

  // Transmitter: records each strobed byte, then reports busy for busy_len cycles.
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (o_byte_tx_valid) begin
        tx_q.push_back(o_byte_tx_data);
        if (busy_len > 0) begin
          @(posedge clk);
          #1 tx_busy = 1'b1;
          repeat (busy_len) @(posedge clk);
          #1 tx_busy = 1'b0;
        end
      end
    end
  end

  // Strobe rules: never while busy, and at least 3 cycles apart.
  initial begin
    int cyc_n;
    int last_pulse;
    cyc_n      = 0;
    last_pulse = -10;
    forever begin
      @(negedge clk);
      if (o_byte_tx_valid) begin
        if (tx_busy) viol++;
        if (cyc_n - last_pulse < 3) viol++;
        last_pulse = cyc_n;
      end
      cyc_n++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!o_busy) break;
    end
    check({name, "_idle_wait"}, o_busy, 1'b0);
  endtask

  function automatic logic [7:0] rand_junk();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    while (b == 8'h57 || b == 8'h52) b = 8'($urandom_range(0, 255));
    return b;
  endfunction

  function automatic vec_t mk(input string name, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input int stall, input int ack_dly, input int busy_l,
                              input int gap, input bit junk_en, input logic [7:0] junk,
                              input bit junk_bus, input bit noack);
    vec_t v;
    v.name = name;   v.we = we;           v.addr = addr;       v.wdata = wdata;
    v.rdata = rdata; v.stall = stall;     v.ack_dly = ack_dly; v.busy_len = busy_l;
    v.gap = gap;     v.junk_en = junk_en; v.junk = junk;       v.junk_bus = junk_bus;
    v.noack = noack;
    return v;
  endfunction

  // Drives one frame and compares bus transaction and response with the frame-level model.
  task automatic run_frame(input vec_t v);
    logic [7:0] bytes[$];
    logic [7:0] exp_tx[$];
    txn_t       t;
    int         exp_cyc;
    cfg_stall   = v.stall;
    cfg_ack_dly = v.ack_dly;
    cfg_rdata   = v.rdata;
    cfg_noack   = v.noack;
    busy_len    = v.busy_len;
    txn_q.delete();
    tx_q.delete();
    stb_cycles  = 0;
    cyc_cycles  = 0;

    if (v.junk_en) begin
      send_byte(v.junk);
      repeat (3) @(negedge clk);
      check({v.name, "_junk_ignored"}, o_busy, 1'b0);
    end

    bytes.push_back(v.we ? 8'h57 : 8'h52);
    for (int i = 3; i >= 0; i--) bytes.push_back(v.addr[8*i +: 8]);
    if (v.we) for (int i = 3; i >= 0; i--) bytes.push_back(v.wdata[8*i +: 8]);
    foreach (bytes[i]) begin
      repeat (v.gap) @(negedge clk);
      send_byte(bytes[i]);
    end
    check({v.name, "_stb_latency"}, {o_wb_cyc, o_wb_stb}, 2'b11);
    if (v.junk_bus) send_byte(rand_junk());
    wait_idle(3000, v.name);

    if (v.noack) begin
      exp_tx.push_back(8'h45);
      exp_cyc = TMO;
    end else begin
      exp_tx.push_back(8'h4B);
      if (!v.we) for (int i = 3; i >= 0; i--) exp_tx.push_back(v.rdata[8*i +: 8]);
      exp_cyc = v.stall + 1 + v.ack_dly;
    end

    check({v.name, "_txn_count"}, txn_q.size(), 1);
    t = '{we: 1'b0, addr: '0, data: '0, sel: '0};
    if (txn_q.size() > 0) t = txn_q[0];
    check({v.name, "_we"}, t.we, v.we);
    check({v.name, "_addr"}, t.addr, v.addr);
    if (v.we) check({v.name, "_wdata"}, t.data, v.wdata);
    check({v.name, "_sel"}, t.sel, 4'hF);
    check({v.name, "_stb_cycles"}, stb_cycles, v.stall + 1);
    check({v.name, "_cyc_cycles"}, cyc_cycles, exp_cyc);
    check({v.name, "_tx_count"}, tx_q.size(), exp_tx.size());
    foreach (exp_tx[i]) begin
      check({v.name, $sformatf("_tx%0d", i)}, (i < tx_q.size()) ? tx_q[i] : 8'hxx, exp_tx[i]);
    end
  endtask

  vec_t vecs[6];

  initial begin
    vec_t rv;
    vec_t wv;

    vecs[0] = mk("w_basic",   1, 32'h0000_8000, 32'hDEAD_BEEF, 32'h0,           0, 1, 0,   0, 0, 8'h00, 0, 0);
    vecs[1] = mk("r_stall",   0, 32'h0000_8000, 32'h0,         32'h1234_5678,   3, 1, 0,   0, 0, 8'h00, 0, 0);
    vecs[2] = mk("r_junk41",  0, 32'h0000_1000, 32'h0,         32'hA5A5_5A5A,   0, 0, 0,   1, 1, 8'h41, 0, 0);
    vecs[3] = mk("r_busy100", 0, 32'hCAFE_0004, 32'h0,         32'h1234_5678,   0, 2, 100, 0, 0, 8'h00, 0, 0);
    vecs[4] = mk("w_edge",    1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0,           1, 0, 0,   2, 0, 8'h00, 0, 0);
    vecs[5] = mk("w_cmdbyte", 1, 32'h5752_5752, 32'h5257_5257, 32'h0,           0, 3, 2,   1, 0, 8'h00, 1, 0);

    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #23;
    check("rst_wb_ctrl", {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_sel}, 7'h0);
    check("rst_wb_addr", o_wb_addr, 32'h0);
    check("rst_wb_data", o_wb_data, 32'h0);
    check("rst_tx", {o_byte_tx_valid, o_byte_tx_data, o_busy}, 10'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) run_frame(vecs[i]);

    // Reset in the middle of a bus cycle.
    cfg_noack = 1'b1;
    txn_q.delete();
    tx_q.delete();
    send_byte(8'h52);
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    repeat (5) @(negedge clk);
    check("midrst_cyc_before", o_wb_cyc, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_cyc_stb", {o_wb_cyc, o_wb_stb}, 2'b00);
    check("midrst_busy", o_busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("midrst_no_tx", tx_q.size(), 0);
    run_frame(mk("w_after_rst", 1, 32'h0000_0040, 32'h0BAD_F00D, 32'h0, 0, 1, 0, 0, 0, 8'h00, 0, 0));

`ifdef UART_WB_TIMEOUT_EN
    run_frame(mk("r_timeout", 0, 32'h0000_2000, 32'h0, 32'h0, 0, 0, 0, 0, 0, 8'h00, 0, 1));
    run_frame(mk("r_after_tmo", 0, 32'h0000_2004, 32'h0, 32'h8765_4321, 1, 1, 1, 0, 0, 8'h00, 0, 0));
`endif

    for (int n = 0; n < 16; n++) begin
      rv.name     = $sformatf("rand%0d", n);
      rv.we       = 1'($urandom_range(0, 1));
      rv.addr     = $urandom;
      rv.wdata    = $urandom;
      rv.rdata    = $urandom;
      rv.stall    = $urandom_range(0, 3);
      rv.ack_dly  = $urandom_range(0, 3);
      rv.busy_len = $urandom_range(0, 4);
      rv.gap      = $urandom_range(0, 2);
      rv.junk_en  = 1'($urandom_range(0, 1));
      rv.junk     = rand_junk();
      rv.junk_bus = 1'($urandom_range(0, 1));
      rv.noack    = 1'b0;
      wv = rv;
      run_frame(wv);
    end

    check("protocol_violations", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_wb_master.md
UART_WB_MASTER -- requirements
Module: uart_wb_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: Wishbone ack timeout, in i_clk cycles.
REQ-002 i_clk  in  1  single system clock; all logic on its rising edge.
REQ-003 in_rst  in  1  reset, asynchronous, active-low.
REQ-004 i_byte_rx_data  in  8  received byte from uart_bridge.
REQ-005 i_byte_rx_valid  in  1  one-cycle strobe; i_byte_rx_data valid.
REQ-006 o_byte_tx_data  out  8  byte to transmit.
REQ-007 o_byte_tx_valid  out  1  one-cycle transmit strobe.
REQ-008 i_byte_tx_busy  in  1  transmitter busy.
REQ-009 o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls.
REQ-010 o_wb_addr  out  32; o_wb_data  out  32; o_wb_sel  out  4, always 4'hF during a cycle.
REQ-011 i_wb_stall, i_wb_ack  in  1 each; i_wb_data  in  32.
REQ-012 o_busy  out  1  high in any state other than IDLE.

Function
REQ-013 Frame: command byte, 4 address bytes MSB first, then for write 4 data bytes MSB first.
REQ-014 Commands: 0x57 'W' = word write; 0x52 'R' = word read; any other byte in IDLE is discarded, no response.
REQ-015 States: IDLE -> ADDR (after valid command) -> DATA (write only, after 4th address byte) -> BUS -> RESP -> IDLE.
REQ-016 Read skips DATA: BUS entered the cycle after the 4th address byte.
REQ-017 BUS entry: o_wb_cyc=o_wb_stb=1, o_wb_we=1 for write; o_wb_addr/o_wb_data stable for the whole cycle.
REQ-018 o_wb_stb held while i_wb_stall=1; deasserted the cycle after a stall-free stb cycle; o_wb_cyc held until ack.
REQ-019 Ack accepted in any BUS cycle, including the stb cycle; read captures i_wb_data on the ack cycle; o_wb_cyc drops the next cycle.
REQ-020 Response: write -> 0x4B 'K'; read -> 'K' then 4 data bytes MSB first; timeout -> single 0x45 'E'.
REQ-021 TX handshake: pulse o_byte_tx_valid only when i_byte_tx_busy=0; no further pulse for 2 cycles after a pulse and until busy=0.
REQ-022 Received bytes in BUS or RESP are dropped; byte counters restart on every new command.
REQ-023 Byte counters are 2-bit and wrap 3->0 on the transition to the next state.
REQ-024 Latency: o_wb_stb asserted exactly 1 cycle after the final frame byte's valid strobe.

Reset
REQ-025 While in_rst=0: state IDLE; all outputs 0; o_wb_addr, o_wb_data, counters and the capture register cleared.
REQ-026 Reset mid-cycle drops o_wb_cyc/o_wb_stb asynchronously; the partial frame and any pending response are discarded.

Configuration
REQ-027 Macro UART_WB_TIMEOUT_EN defined: counter counts BUS cycles; reaching TIMEOUT_CYCLES with no ack drops cyc/stb and sends 'E'.
REQ-028 Macro undefined: no counter logic; BUS waits indefinitely for ack; 'E' never sent.

Structure
REQ-029 Shared package uart_wb_pkg holds the command codes (0x57, 0x52), response codes (0x4B, 0x45) and the state enumeration.
REQ-030 One sub-module, uart_wb_txser, serialises 1 or 5 response bytes under the busy handshake; everything else stays in uart_wb_master.

Verification
REQ-031 Bytes 57 00 00 80 00 DE AD BE EF, slave acks in 1 cycle -> one write, addr 0x00008000, data 0xDEADBEEF, sel F; TX 4B.
REQ-032 Bytes 52 00 00 80 00, slave returns 0x12345678 with stall=1 for 3 cycles -> stb high 4 cycles; TX 4B 12 34 56 78.
REQ-033 Byte 0x41, then a valid read frame -> 0x41 ignored; read completes normally.
REQ-034 UART_WB_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, no ack -> cyc drops after 16 cycles; TX 45; next frame works.
REQ-035 Reset asserted mid-BUS -> cyc/stb 0 immediately; no TX; following write frame completes.
REQ-036 i_byte_tx_busy held high for 100 cycles during a read response -> 5 bytes in order, none lost or duplicated.
